// File: rtl/slave_out_port_pkg.sv
// Shared definitions for the slave output port and the master input stage:
// state encoding and default word/burst geometry.
package slave_out_port_pkg;

   localparam int unsigned DefaultWordSize  = 8;
   localparam int unsigned DefaultBurstSize = 12;

   typedef logic [1:0] state_t;

   localparam state_t StIdle      = 2'd0;
   localparam state_t StFetch     = 2'd1;
   localparam state_t StHandshake = 2'd2;
   localparam state_t StSend      = 2'd3;

   // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/slave_out_port_if.sv
// Core-side and bus-side signals of the slave output port. The slave modport is the
// port block itself; the master modport is whatever drives it (core plus master stage).
interface slave_out_port_if
   import slave_out_port_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = DefaultWordSize,
   parameter int unsigned BURST_SIZE = DefaultBurstSize
);

   logic                  start;
   logic [BURST_SIZE-1:0] burst_num;
   logic [WORD_SIZE-1:0]  din;
   logic                  din_valid;
   logic                  din_ready;
   logic                  master_ready;
   logic                  tx_data;
   logic                  slave_valid;
   logic                  busy;
   logic                  tx_done;

   modport slave (
      input  start,
      input  burst_num,
      input  din,
      input  din_valid,
      input  master_ready,
      output din_ready,
      output tx_data,
      output slave_valid,
      output busy,
      output tx_done
   );

   modport master (
      output start,
      output burst_num,
      output din,
      output din_valid,
      output master_ready,
      input  din_ready,
      input  tx_data,
      input  slave_valid,
      input  busy,
      input  tx_done
   );

endinterface

// File: rtl/slave_out_port_piso_shift.sv
// Parallel-load, LSB-first shift register. serial_o is bit 0 of the register, so it
// is a flop output; clear_i empties the register so the serial line idles at 0.
module piso_shift #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             serial_o
);

   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      data_d = data_q;
      if (clear_i) begin
         data_d = '0;
      end else if (load_i) begin
         data_d = data_i;
      end else if (shift_i) begin
         data_d = data_q >> 1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign serial_o = data_q[0];

endmodule

// File: rtl/slave_out_port.sv
// Slave output port: fetches words from the slave core, offers bit 0 with slave_valid,
// and after the master accepts streams the remaining bits LSB first, one per cycle.
module slave_out_port
   import slave_out_port_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = DefaultWordSize,
   parameter int unsigned BURST_SIZE = DefaultBurstSize
) (
   input  logic            clk,
   input  logic            reset,
   slave_out_port_if.slave bus
);

   localparam int unsigned BitCntW = cnt_width(WORD_SIZE);
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(WORD_SIZE - 1);

   state_t                state_d, state_q;
   logic [BURST_SIZE-1:0] burst_d, burst_q;
   logic [BURST_SIZE-1:0] word_cnt_d, word_cnt_q;
   logic [BitCntW-1:0]    bit_cnt_d, bit_cnt_q;
   logic                  din_ready_d, din_ready_q;
   logic                  slave_valid_d, slave_valid_q;
   logic                  busy_d, busy_q;
   logic                  tx_done_d, tx_done_q;

   logic sh_load, sh_shift, sh_clear;
   logic word_done;
   logic serial;

   always_comb begin
      state_d       = state_q;
      burst_d       = burst_q;
      word_cnt_d    = word_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      din_ready_d   = din_ready_q;
      slave_valid_d = slave_valid_q;
      busy_d        = busy_q;
      tx_done_d     = 1'b0;
      sh_load       = 1'b0;
      sh_shift      = 1'b0;
      word_done     = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               burst_d     = bus.burst_num;
               word_cnt_d  = '0;
               state_d     = StFetch;
               din_ready_d = 1'b1;
               busy_d      = 1'b1;
            end
         end
         StFetch: begin
            if (bus.din_valid && din_ready_q) begin
               sh_load       = 1'b1;
               state_d       = StHandshake;
               din_ready_d   = 1'b0;
               slave_valid_d = 1'b1;
            end
         end
         StHandshake: begin
            if (bus.master_ready) begin
               sh_shift      = 1'b1;
               bit_cnt_d     = BitCntW'(1);
               slave_valid_d = 1'b0;
               state_d       = StSend;
               // A one-bit word has nothing left to send after the handshake.
               if (WORD_SIZE == 1) word_done = 1'b1;
            end
         end
         StSend: begin
            sh_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            if (bit_cnt_q == LastBit) word_done = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Compare before increment so an all-ones burst_num never wraps word_cnt.
      if (word_done) begin
         if (word_cnt_q < burst_q) begin
            word_cnt_d  = word_cnt_q + BURST_SIZE'(1);
            state_d     = StFetch;
            din_ready_d = 1'b1;
         end else begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            tx_done_d = 1'b1;
         end
      end
   end

   assign sh_clear = word_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         burst_q       <= '0;
         word_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         din_ready_q   <= 1'b0;
         slave_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         tx_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         burst_q       <= burst_d;
         word_cnt_q    <= word_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         din_ready_q   <= din_ready_d;
         slave_valid_q <= slave_valid_d;
         busy_q        <= busy_d;
         tx_done_q     <= tx_done_d;
      end
   end

   piso_shift #(
      .WIDTH (WORD_SIZE)
   ) u_piso_shift (
      .clk_i    (clk),
      .rst_ni   (reset),
      .clear_i  (sh_clear),
      .load_i   (sh_load),
      .shift_i  (sh_shift),
      .data_i   (bus.din),
      .serial_o (serial)
   );

   assign bus.din_ready   = din_ready_q;
   assign bus.slave_valid = slave_valid_q;
   assign bus.busy        = busy_q;
   assign bus.tx_done     = tx_done_q;
   assign bus.tx_data     = serial;

endmodule

// File: tb/tb_slave_out_port.sv
// Bench for slave_out_port: a core model feeds words, a master model reassembles the
// serial stream, and received words, tx_done and timing are compared to expectations.
module tb_slave_out_port;
   import slave_out_port_pkg::*;

   localparam int unsigned W = DefaultWordSize;
   localparam int unsigned B = DefaultBurstSize;

   typedef logic [W-1:0] word_q_t[$];

   typedef struct {
      int         burst;
      logic [7:0] w0;
      logic [7:0] w1;
      logic [7:0] w2;
      int         hs_stall;
      int         f_stall;
      int         exp_cycles;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   slave_out_port_if #(.WORD_SIZE(W), .BURST_SIZE(B)) bus ();

   slave_out_port #(
      .WORD_SIZE  (W),
      .BURST_SIZE (B)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [W-1:0] rx_q[$];
   logic [W-1:0] rx_word;
   int         rx_bit;
   bit         collecting;
   int         acc_cnt;
   int         done_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic mon_clear();
      rx_q.delete();
      collecting = 1'b0;
      rx_bit     = 0;
      acc_cnt    = 0;
      done_cnt   = 0;
   endtask

   // One clock: sample handshakes before the edge, then collect bits after it.
   task automatic step();
      bit   hs, acc;
      logic pre_tx;
      hs     = bus.slave_valid && bus.master_ready;
      acc    = bus.din_valid && bus.din_ready;
      pre_tx = bus.tx_data;
      @(posedge clk);
      #1;
      if (acc) acc_cnt++;
      if (bus.tx_done) done_cnt++;
      if (hs) begin
         rx_word    = '0;
         rx_word[0] = pre_tx;
         rx_bit     = 1;
         collecting = 1'b1;
      end
      if (collecting) begin
         rx_word[rx_bit] = bus.tx_data;
         rx_bit++;
         check("quiet_during_word", {30'd0, bus.slave_valid, bus.din_ready}, 32'd0);
         if (rx_bit == W) begin
            rx_q.push_back(rx_word);
            collecting = 1'b0;
         end
      end else if (!bus.slave_valid) begin
         check("tx_idle_zero", {31'd0, bus.tx_data}, 32'd0);
      end
      if (bus.din_ready) check("ready_implies_busy", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic run_burst(input int burst, input word_q_t words, input int hs_stall,
                            input int f_stall, input bit rnd, input bit spam,
                            input int abort_bit, output int cycles);
      int budget;
      int h_left, f_left;
      bit seen;
      mon_clear();
      h_left = hs_stall;
      f_left = f_stall;
      budget = 1 + (burst + 1) * (W + 1) + hs_stall + f_stall + (rnd ? 40 * (burst + 1) + 50 : 20);
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < budget) begin
         if (cycles == 0) begin
            bus.start     = 1'b1;
            bus.burst_num = B'(burst);
         end else begin
            bus.start     = spam && bus.busy && ($urandom % 3 == 0);
            bus.burst_num = B'($urandom);
         end
         bus.din = (acc_cnt < words.size()) ? words[acc_cnt] : W'($urandom);
         if (bus.din_ready) check("fetch_no_valid", {31'd0, bus.slave_valid}, 32'd0);
         if (bus.din_ready && acc_cnt == 1 && f_left > 0) begin
            bus.din_valid = 1'b0;
            f_left--;
         end else begin
            bus.din_valid = rnd ? ($urandom % 4 != 0) : 1'b1;
         end
         if (bus.slave_valid) begin
            if (acc_cnt >= 1 && acc_cnt <= words.size())
               check("hs_bit0", {31'd0, bus.tx_data}, {31'd0, words[acc_cnt-1][0]});
            if (acc_cnt == 1 && h_left > 0) begin
               bus.master_ready = 1'b0;
               h_left--;
            end else begin
               bus.master_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
            end
         end else begin
            bus.master_ready = 1'($urandom % 2);
         end
         step();
         cycles++;
         if (abort_bit >= 0 && collecting && rx_q.size() == 1 && rx_bit == abort_bit + 1) return;
         if (done_cnt > 0) seen = 1'b1;
      end
      if (!seen) check("tx_done_seen", done_cnt, 1);
      bus.start     = 1'b0;
      bus.din_valid = 1'b0;
      repeat (2) step();
   endtask

   task automatic verify(input string tag, input word_q_t words);
      check({tag, "_word_count"}, rx_q.size(), words.size());
      for (int i = 0; i < words.size() && i < rx_q.size(); i++)
         check($sformatf("%s_word%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, words[i]});
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_din_ready"}, {31'd0, bus.din_ready}, 32'd0);
      check({tag, "_tx_data"}, {31'd0, bus.tx_data}, 32'd0);
      check({tag, "_slave_valid"}, {31'd0, bus.slave_valid}, 32'd0);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_tx_done"}, {31'd0, bus.tx_done}, 32'd0);
   endtask

   initial begin
      vec_t    vecs[5];
      word_q_t wq;
      int      cyc;
      int      n;

      vecs[0] = '{0, 8'hA5, 8'h00, 8'h00, 0, 0, 10};
      vecs[1] = '{2, 8'h01, 8'h80, 8'hFF, 0, 0, 28};
      vecs[2] = '{0, 8'h3C, 8'h00, 8'h00, 5, 0, 15};
      vecs[3] = '{2, 8'h11, 8'h22, 8'h33, 0, 4, 32};
      vecs[4] = '{1, 8'h5A, 8'hC3, 8'h00, 3, 2, 24};

      reset            = 1'b0;
      bus.start        = 1'b0;
      bus.burst_num    = '0;
      bus.din          = '0;
      bus.din_valid    = 1'b0;
      bus.master_ready = 1'b0;
      mon_clear();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset = 1'b1;
      repeat (2) step();

      // Directed table: single word, burst, handshake stall, core starvation.
      for (int v = 0; v < 5; v++) begin
         wq = {};
         wq.push_back(vecs[v].w0);
         if (vecs[v].burst >= 1) wq.push_back(vecs[v].w1);
         if (vecs[v].burst >= 2) wq.push_back(vecs[v].w2);
         run_burst(vecs[v].burst, wq, vecs[v].hs_stall, vecs[v].f_stall, 1'b0, 1'b0, -1, cyc);
         check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
         verify($sformatf("vec%0d", v), wq);
      end

      // Reset while bit 3 of the second word is on the line.
      wq = {8'h11, 8'h22, 8'h33};
      run_burst(2, wq, 0, 0, 1'b0, 1'b0, 3, cyc);
      check("abort_words_before", rx_q.size(), 1);
      check("abort_bit3", {31'd0, bus.tx_data}, 32'd0);
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      reset = 1'b1;
      mon_clear();
      bus.start        = 1'b0;
      bus.din_valid    = 1'b1;
      bus.master_ready = 1'b1;
      repeat (5) step();
      check("post_rst_no_done", done_cnt, 0);
      check("post_rst_idle", {30'd0, bus.busy, bus.din_ready}, 32'd0);
      wq = {8'h6B};
      run_burst(0, wq, 0, 0, 1'b0, 1'b0, -1, cyc);
      check("post_rst_cycles", cyc, 10);
      verify("post_rst", wq);

      // Start pulses while busy must be ignored.
      for (int b = 0; b < 2; b++) begin
         wq = {};
         for (int i = 0; i <= b; i++) wq.push_back(W'($urandom));
         run_burst(b, wq, 0, 0, 1'b0, 1'b1, -1, cyc);
         check($sformatf("b2b%0d_cycles", b), cyc, 1 + (b + 1) * (W + 1));
         verify($sformatf("b2b%0d", b), wq);
      end

      // Randomized handshakes and starvation against the word-level model.
      for (int r = 0; r < 6; r++) begin
         n  = $urandom_range(0, 5);
         wq = {};
         for (int i = 0; i <= n; i++) wq.push_back(W'($urandom));
         run_burst(n, wq, 0, 0, 1'b1, 1'b1, -1, cyc);
         verify($sformatf("rnd%0d", r), wq);
      end

      // Largest burst: 2^BURST_SIZE words with no counter wrap.
      wq = {};
      for (int i = 0; i < (1 << B); i++) wq.push_back(W'($urandom));
      run_burst((1 << B) - 1, wq, 0, 0, 1'b0, 1'b1, -1, cyc);
      check("max_cycles", cyc, 1 + (1 << B) * (W + 1));
      verify("max", wq);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
